muldiv_issue_ctrl: RTL and testbench
====================================

// Module: muldiv_issue_ctrl
// PURPOSE
//  Initiator side of the iterative 33-bit shift-add multiplier/divider. Accepts RV32M ops from EX.
//  Formats 33-bit operands, pulses Run, tracks ready, applies sign fix-up, returns 32-bit result.
//  Stalls the pipeline while busy; resolves div-by-zero, overflow and operand-reuse hits without the unit.
// PARAMETERS
//  TIMEOUT   256  max cycles in WAIT_DONE before err pulses and FSM returns to IDLE
//  REUSE_EN  1    1 = return cached product for matching MUL/MULH* pair without relaunch
// PORTS
//  Clk          in   1   clock, all state on rising edge
//  Reset_n      in   1   asynchronous, active-low reset
//  req_valid    in   1   EX presents an M op this cycle
//  funct3       in   3   0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  rs1, rs2     in   32  operands
//  flush        in   1   kill current op (branch/trap)
//  stall        out  1   hold EX; high from accept until result_valid
//  result       out  32  rd value, valid with result_valid
//  result_valid out  1   one-cycle pulse
//  err          out  1   one-cycle pulse on timeout
//  Run          out  1   start pulse to unit
//  opA, opB     out  33  unit operands
//  div          out  1   unit mode, 1 = divide; held stable LAUNCH..WAIT_DONE
//  Aval, Bval   in   33  unit result registers
//  ready        in   1   unit idle/done
// BEHAVIOUR
//  Reset: IDLE; stall,result_valid,err,Run,div=0; result,opA,opB=0; reuse cache invalid.
//  Unit contract, multiply: product P = {Aval,Bval} (66b, signed).
//   MUL = Bval[31:0]; MULH* = {Aval[30:0],Bval[32]}.
//  Unit contract, divide: unsigned magnitudes; quotient in Bval[31:0], remainder in Aval[31:0].
//  Operand format, mul: rs1 sign-extended to 33b for MULH/MULHSU, else zero-extended.
//   rs2 sign-extended for MULH only, else zero-extended.
//  Operand format, div: opA={0,|rs1|}, opB={0,|rs2|}; abs only for DIV/REM, else zero-ext.
//   |0x80000000| = 0x80000000 unsigned.
//  FSM IDLE: req_valid & ~flush accepts; operands and funct3 latched.
//   -> FAST if special case or reuse hit, else LAUNCH. stall rises the cycle after accept.
//  FSM LAUNCH: Run=1 exactly one cycle, opA/opB/div driven -> WAIT_BUSY.
//  FSM WAIT_BUSY: wait ready==0 -> WAIT_DONE. Counter runs from LAUNCH.
//  FSM WAIT_DONE: ready==1 -> FIXUP; counter==TIMEOUT -> err pulse, IDLE, stall drops.
//  FSM FIXUP: signed negate per rules below; capture result -> DONE.
//  FSM DONE: result_valid=1, stall=0 same cycle -> IDLE.
//  FSM FAST: result computed combinationally from latched ops -> DONE (2-cycle latency).
//  Special cases (no launch), rs2==0: DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> rs1.
//  Special case DIV/REM overflow, rs1=0x80000000 & rs2=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0.
//  Sign fix-up: DIV quotient negated iff rs1[31]^rs2[31]; REM remainder negated iff rs1[31].
//   Both mod 2^32.
//  Reuse cache: after any mul completes, store {rs1,rs2,signedness class,P}.
//   Class = funct3 for MULH* and MUL is class-agnostic for low word.
//   Later MUL/MULH* with equal rs1,rs2 and compatible class hits -> FAST. Any div leaves cache intact.
//   REUSE_EN=0 never hits.
//  flush in LAUNCH/WAIT_*: enter DRAIN, stall=0 immediately. No result_valid, cache not updated.
//  DRAIN: waits ready 0->1 (or TIMEOUT) then IDLE. New req in DRAIN is not accepted.
//   stall=1 if req_valid present.
//  flush in FIXUP/FAST/DONE: result_valid suppressed, -> IDLE.
//  flush and req_valid in IDLE same cycle: flush wins, no accept.
//  Run never asserted while ready==0. div never changes while unit busy.
//  Reset_n low mid-operation: FSM to IDLE immediately.
//   Unit is reset by same Reset_n; no drain needed.
// TESTING
//  MUL 7*-3 -> result 0xFFFFFFEB; Run pulsed once; stall high until pulse.
//  MULH 0x80000000*0x80000000 -> 0x40000000.
//   Then MUL same operands -> 0x00000000 with no Run (reuse hit, 2 cycles).
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF.
//  DIV x/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000. No Run, result_valid at cycle 2.
//  flush 3 cycles after MULHU launch -> stall drops next cycle, no result_valid.
//   New req held off until ready returns high, then runs correctly.
//  Unit ready held low forever -> err pulse at TIMEOUT cycles, FSM IDLE. Reset_n asserted mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/muldiv_issue_ctrl_if.sv
// rtl/muldiv_issue_ctrl_if.sv - EX request/response and multiply/divide unit signal bundle
interface muldiv_issue_ctrl_if;
    logic        req_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic        err;
    logic        Run;
    logic [32:0] opA;
    logic [32:0] opB;
    logic        div;
    logic [32:0] Aval;
    logic [32:0] Bval;
    logic        ready;

    modport master (
        input  req_valid, funct3, rs1, rs2, flush, Aval, Bval, ready,
        output stall, result, result_valid, err, Run, opA, opB, div
    );

    modport slave (
        output req_valid, funct3, rs1, rs2, flush, Aval, Bval, ready,
        input  stall, result, result_valid, err, Run, opA, opB, div
    );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// rtl/muldiv_issue_ctrl.sv - RV32M issue controller for an iterative 33-bit multiply/divide unit
module muldiv_issue_ctrl #(
    parameter int TIMEOUT  = 256,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    muldiv_issue_ctrl_if.master  bus
);

    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_FIXUP, S_DONE, S_FAST, S_DRAIN
    } state_t;

    state_t        state;
    logic [31:0]   a_q, b_q;
    logic [2:0]    f3_q;
    logic [CW-1:0] cnt;
    logic          stall_q, rv_q, err_q, run_q, div_q, drain_seen;
    logic [31:0]   result_q;
    logic [32:0]   opa_q, opb_q;

    logic          cache_vld;
    logic [31:0]   c_rs1, c_rs2;
    logic [2:0]    c_cls;
    logic [63:0]   c_prod;

    logic          in_is_div, in_special, in_hit;
    logic          mul_a_sx, mul_b_sx, div_sgn;
    logic [31:0]   abs_a, abs_b;
    logic [32:0]   fmt_a, fmt_b;
    logic [31:0]   prod_lo, prod_hi, quo, rem, fix_res, fast_res;
    logic          unused_aval_msb;

    assign unused_aval_msb = bus.Aval[32];

    always_comb begin
        in_is_div  = bus.funct3[2];
        in_special = in_is_div && ((bus.rs2 == 32'd0) ||
                     (!bus.funct3[0] && bus.rs1 == 32'h8000_0000 && bus.rs2 == 32'hFFFF_FFFF));
        in_hit     = REUSE_EN && cache_vld && !in_is_div &&
                     bus.rs1 == c_rs1 && bus.rs2 == c_rs2 &&
                     (bus.funct3 == 3'd0 || bus.funct3 == c_cls);
    end

    always_comb begin
        mul_a_sx = (f3_q == 3'd1) || (f3_q == 3'd2);
        mul_b_sx = (f3_q == 3'd1);
        div_sgn  = !f3_q[0];
        abs_a    = (div_sgn && a_q[31]) ? (~a_q + 32'd1) : a_q;
        abs_b    = (div_sgn && b_q[31]) ? (~b_q + 32'd1) : b_q;
        if (f3_q[2]) begin
            fmt_a = {1'b0, abs_a};
            fmt_b = {1'b0, abs_b};
        end else begin
            fmt_a = {mul_a_sx & a_q[31], a_q};
            fmt_b = {mul_b_sx & b_q[31], b_q};
        end
    end

    always_comb begin
        prod_lo = bus.Bval[31:0];
        prod_hi = {bus.Aval[30:0], bus.Bval[32]};
        quo     = bus.Bval[31:0];
        rem     = bus.Aval[31:0];
        case (f3_q)
            3'd0:    fix_res = prod_lo;
            3'd4:    fix_res = (a_q[31] ^ b_q[31]) ? (~quo + 32'd1) : quo;
            3'd5:    fix_res = quo;
            3'd6:    fix_res = a_q[31] ? (~rem + 32'd1) : rem;
            3'd7:    fix_res = rem;
            default: fix_res = prod_hi;
        endcase
    end

    always_comb begin
        fast_res = 32'd0;
        if (f3_q[2]) begin
            if (b_q == 32'd0) begin
                fast_res = f3_q[1] ? a_q : 32'hFFFF_FFFF;
            end else begin
                fast_res = f3_q[1] ? 32'd0 : 32'h8000_0000;
            end
        end else begin
            fast_res = (f3_q == 3'd0) ? c_prod[31:0] : c_prod[63:32];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            f3_q       <= '0;
            cnt        <= '0;
            stall_q    <= 1'b0;
            rv_q       <= 1'b0;
            err_q      <= 1'b0;
            run_q      <= 1'b0;
            div_q      <= 1'b0;
            drain_seen <= 1'b0;
            result_q   <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            cache_vld  <= 1'b0;
            c_rs1      <= '0;
            c_rs2      <= '0;
            c_cls      <= '0;
            c_prod     <= '0;
        end else begin
            rv_q  <= 1'b0;
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid && !bus.flush) begin
                        a_q     <= bus.rs1;
                        b_q     <= bus.rs2;
                        f3_q    <= bus.funct3;
                        stall_q <= 1'b1;
                        cnt     <= '0;
                        run_q   <= 1'b0;
                        state   <= (in_special || in_hit) ? S_FAST : S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt <= cnt + CW'(1);
                    if (bus.flush) begin
                        stall_q    <= 1'b0;
                        run_q      <= 1'b0;
                        drain_seen <= 1'b0;
                        state      <= run_q ? S_DRAIN : S_IDLE;
                    end else if (run_q) begin
                        run_q <= 1'b0;
                        state <= S_WAIT_BUSY;
                    end else if (bus.ready) begin
                        run_q <= 1'b1;
                        opa_q <= fmt_a;
                        opb_q <= fmt_b;
                        div_q <= f3_q[2];
                    end else if (cnt == TO_CNT) begin
                        err_q   <= 1'b1;
                        stall_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_WAIT_BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (bus.flush) begin
                        stall_q    <= 1'b0;
                        drain_seen <= !bus.ready;
                        state      <= S_DRAIN;
                    end else if (!bus.ready) begin
                        state <= S_WAIT_DONE;
                    end else if (cnt == TO_CNT) begin
                        err_q   <= 1'b1;
                        stall_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_WAIT_DONE: begin
                    cnt <= cnt + CW'(1);
                    if (bus.flush) begin
                        stall_q    <= 1'b0;
                        drain_seen <= 1'b1;
                        state      <= S_DRAIN;
                    end else if (bus.ready) begin
                        state <= S_FIXUP;
                    end else if (cnt == TO_CNT) begin
                        err_q   <= 1'b1;
                        stall_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_FIXUP: begin
                    stall_q <= 1'b0;
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        result_q <= fix_res;
                        rv_q     <= 1'b1;
                        state    <= S_DONE;
                        if (!f3_q[2]) begin
                            cache_vld <= 1'b1;
                            c_rs1     <= a_q;
                            c_rs2     <= b_q;
                            c_cls     <= (f3_q == 3'd0) ? 3'd3 : f3_q;
                            c_prod    <= {prod_hi, prod_lo};
                        end
                    end
                end
                S_FAST: begin
                    stall_q <= 1'b0;
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        result_q <= fast_res;
                        rv_q     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_DRAIN: begin
                    cnt <= cnt + CW'(1);
                    if (!bus.ready) begin
                        drain_seen <= 1'b1;
                    end
                    if ((drain_seen && bus.ready) || cnt == TO_CNT) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall        = stall_q || (state == S_DRAIN && bus.req_valid);
    assign bus.result       = result_q;
    assign bus.result_valid = rv_q && !bus.flush;
    assign bus.err          = err_q;
    assign bus.Run          = run_q;
    assign bus.opA          = opa_q;
    assign bus.opB          = opb_q;
    assign bus.div          = div_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb/tb_muldiv_issue_ctrl.sv - scoreboard bench for muldiv_issue_ctrl with a behavioural unit model
module tb_muldiv_issue_ctrl;

    localparam int TO = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_issue_ctrl_if bus();

    muldiv_issue_ctrl #(.TIMEOUT(TO), .REUSE_EN(1'b1)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int run_cnt = 0;
    int rv_cnt = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    bit          hang = 1'b0;
    int          ucnt;
    logic [32:0] ua, ub;
    logic        udiv;

    function automatic logic [65:0] unit_calc(input logic [32:0] a, input logic [32:0] b, input logic d);
        logic [65:0] sa, sb;
        if (d) begin
            if (b == 33'd0) return {a, 33'h1_FFFF_FFFF};
            return {a % b, a / b};
        end
        sa = {{33{a[32]}}, a};
        sb = {{33{b[32]}}, b};
        return sa * sb;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ready <= 1'b1;
            bus.Aval  <= '0;
            bus.Bval  <= '0;
            ucnt      <= 0;
            ua        <= '0;
            ub        <= '0;
            udiv      <= 1'b0;
        end else if (bus.Run && bus.ready) begin
            bus.ready <= 1'b0;
            ucnt      <= 8;
            ua        <= bus.opA;
            ub        <= bus.opB;
            udiv      <= bus.div;
        end else if (!bus.ready && !hang) begin
            if (ucnt == 1) begin
                bus.ready <= 1'b1;
                {bus.Aval, bus.Bval} <= unit_calc(ua, ub, udiv);
            end
            ucnt <= ucnt - 1;
        end
    end

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, req);
        end
    endtask

    initial begin
        logic [31:0] e;
        string nm;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.Run) run_cnt++;
                if (bus.Run && !bus.ready) begin
                    n_err++;
                    $display("FAIL run_while_busy: Run=1 with ready=0");
                end
                if (!bus.ready && !bus.Run && bus.div !== udiv) begin
                    n_err++;
                    $display("FAIL div_changed_busy: actual %0b required %0b", bus.div, udiv);
                end
                if (bus.result_valid) begin
                    rv_cnt++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_result: actual 0x%08h required no result_valid", bus.result);
                    end else begin
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        if (bus.result !== e) begin
                            n_err++;
                            $display("FAIL %s: actual 0x%08h required 0x%08h", nm, bus.result, e);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.funct3    = f;
        bus.rs1       = a;
        bus.rs2       = b;
        for (int w = 0; w < 200; w++) begin
            #1;
            if (!bus.stall) begin
                ok = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: actual stall=1 required stall=0");
        end
    endtask

    task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input bit fast, output int waits);
        int r0, lat;
        bit seen, st_ok;
        r0 = run_cnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        send(f, a, b, waits);
        lat = 0;
        seen = 1'b0;
        st_ok = 1'b1;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (bus.result_valid) begin
                seen = 1'b1;
                if (bus.stall) st_ok = 1'b0;
                break;
            end else if (!bus.stall) begin
                st_ok = 1'b0;
            end
        end
        check32({nm, "_seen"}, 32'(seen), 32'd1);
        if (!seen) void'(exp_q.pop_back());
        if (!seen) void'(name_q.pop_back());
        check32({nm, "_stall"}, 32'(st_ok), 32'd1);
        check32({nm, "_runs"}, 32'(run_cnt - r0), fast ? 32'd0 : 32'd1);
        if (fast) check32({nm, "_latency"}, 32'(lat), 32'd2);
    endtask

    task automatic op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input bit fast);
        int w;
        issue(nm, f, a, b, e, fast, w);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, v0, w, lat;
        bit got;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.funct3    = 3'd0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        repeat (3) @(negedge clk);
        check32("reset_ctrl", {27'd0, bus.stall, bus.result_valid, bus.err, bus.Run, bus.div}, 32'd0);
        check32("reset_result", bus.result, 32'd0);
        check32("reset_ops", bus.opA[31:0] | bus.opB[31:0] | {31'd0, bus.opA[32] | bus.opB[32]}, 32'd0);
        rst_n = 1'b1;

        op("mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        op("mulh_min",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
        op("mul_reuse",     3'd0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1);
        op("mulhsu_m1_2",   3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0);
        op("mulhu_cls",     3'd3, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 1'b0);
        op("mulhu_reuse",   3'd3, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 1'b1);
        op("div_m7_2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
        op("rem_m7_2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
        op("divu_big",      3'd5, 32'hFFFF_FFFE,  32'd2,         32'h7FFF_FFFF, 1'b0);
        op("remu_100_7",    3'd7, 32'd100,        32'd7,         32'd2,         1'b0);
        op("div_min_2",     3'd4, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0);
        op("div_20_m6",     3'd4, 32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD, 1'b0);
        op("rem_20_m6",     3'd6, 32'd20,         32'hFFFF_FFFA, 32'd2,         1'b0);
        op("div_by0",       3'd4, 32'd7,          32'd0,         32'hFFFF_FFFF, 1'b1);
        op("divu_by0",      3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1);
        op("remu_by0",      3'd7, 32'd5,          32'd0,         32'd5,         1'b1);
        op("rem_by0",       3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b1);
        op("div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        op("rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1);
        op("mul_after_div", 3'd0, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1);

        r0 = run_cnt;
        v0 = rv_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        bus.funct3    = 3'd0;
        bus.rs1       = 32'd2;
        bus.rs2       = 32'd3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        repeat (3) @(negedge clk);
        check32("flush_idle_stall", 32'(bus.stall), 32'd0);
        check32("flush_idle_runs", 32'(run_cnt - r0), 32'd0);
        check32("flush_idle_results", 32'(rv_cnt - v0), 32'd0);

        r0 = run_cnt;
        v0 = rv_cnt;
        send(3'd3, 32'd3, 32'd5, w);
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check32("flush_stall_drop", 32'(bus.stall), 32'd0);
        issue("mul_after_flush", 3'd0, 32'd6, 32'd7, 32'd42, 1'b0, w);
        check32("flush_held_off", 32'(w > 0), 32'd1);
        check32("flush_results", 32'(rv_cnt - v0), 32'd1);
        check32("flush_runs", 32'(run_cnt - r0), 32'd2);

        hang = 1'b1;
        v0 = rv_cnt;
        send(3'd5, 32'd9, 32'd3, w);
        lat = 0;
        got = 1'b0;
        while (lat < TO + 20) begin
            @(negedge clk);
            lat++;
            if (bus.err) begin
                got = 1'b1;
                break;
            end
        end
        check32("timeout_err", 32'(got), 32'd1);
        check32("timeout_window", 32'(lat >= TO && lat <= TO + 2), 32'd1);
        check32("timeout_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        check32("timeout_err_pulse", 32'(bus.err), 32'd0);
        check32("timeout_no_result", 32'(rv_cnt - v0), 32'd0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hang = 1'b1;
        send(3'd4, 32'd100, 32'd7, w);
        repeat (6) @(negedge clk);
        check32("mid_busy_stall", 32'(bus.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check32("mid_reset_ctrl", {27'd0, bus.stall, bus.result_valid, bus.err, bus.Run, bus.div}, 32'd0);
        check32("mid_reset_result", bus.result, 32'd0);
        check32("mid_reset_ops", bus.opA[31:0] | bus.opB[31:0] | {31'd0, bus.opA[32] | bus.opB[32]}, 32'd0);
        @(negedge clk);
        hang = 1'b0;
        rst_n = 1'b1;
        op("div_after_reset", 3'd4, 32'd100, 32'd7, 32'd14, 1'b0);

        repeat (3) @(negedge clk);
        check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
